// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: decodes one instruction per cycle into a registered control word.
// Block transfers (mode 3) are expanded into micro-ops only when CTRL_BLOCK_XFER_EN is defined.
module ctrl_sequencer #(
  parameter int RLIST_W = 16,
  parameter int IDX_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  input  logic [1:0]         mode,
  input  logic [3:0]         opcode,
  input  logic               s,
  input  logic [RLIST_W-1:0] reg_list,
  input  logic               stall,
  input  logic               flush,
  output logic               in_ready,
  output logic               busy,
  output logic               out_valid,
  output logic               mem_r_en,
  output logic               mem_w_en,
  output logic               wb_en,
  output logic               b,
  output logic               stat_update,
  output logic [3:0]         exe_cmd,
  output logic [IDX_W-1:0]   uop_reg,
  output logic               uop_last
);

  typedef struct packed {
    logic             vld;
    logic             mem_r;
    logic             mem_w;
    logic             wb;
    logic             br;
    logic             stat;
    logic [3:0]       cmd;
    logic [IDX_W-1:0] idx;
    logic             last;
  } ctrl_t;

  localparam ctrl_t CTRL_ZERO = '0;

  ctrl_t ctrl_r;
  ctrl_t ctrl_nxt_s;

  function automatic ctrl_t decode_single(input logic [1:0] m, input logic [3:0] op,
                                          input logic sb);
    ctrl_t c;
    c = CTRL_ZERO;
    case (m)
      2'd0: begin
        c.vld  = 1'b1;
        c.stat = sb;
        case (op)
          4'd0:    {c.cmd, c.wb} = 5'b0110_1;
          4'd1:    {c.cmd, c.wb} = 5'b1000_1;
          4'd2:    {c.cmd, c.wb} = 5'b0100_1;
          4'd4:    {c.cmd, c.wb} = 5'b0010_1;
          4'd5:    {c.cmd, c.wb} = 5'b0011_1;
          4'd6:    {c.cmd, c.wb} = 5'b0101_1;
          4'd8:    {c.cmd, c.wb} = 5'b0110_0;
          4'd10:   {c.cmd, c.wb} = 5'b0100_0;
          4'd12:   {c.cmd, c.wb} = 5'b0111_1;
          4'd13:   {c.cmd, c.wb} = 5'b0001_1;
          4'd15:   {c.cmd, c.wb} = 5'b1001_1;
          default: {c.cmd, c.wb} = 5'b0000_0;
        endcase
      end
      2'd1: begin
        c.vld = 1'b1;
        if (op == 4'd4) begin
          c.cmd = 4'b0010;
          if (sb) begin
            c.wb    = 1'b1;
            c.mem_r = 1'b1;
          end else begin
            c.mem_w = 1'b1;
          end
        end else begin
          c.cmd = 4'b0000;
        end
      end
      2'd2: begin
        c.vld = 1'b1;
        c.br  = 1'b1;
      end
      // Mode 3 lands here only as a bubble; the sequencer handles it otherwise.
      default: c = CTRL_ZERO;
    endcase
    return c;
  endfunction

`ifdef CTRL_BLOCK_XFER_EN
  typedef enum logic [0:0] {IDLE = 1'b0, BLOCK = 1'b1} state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [RLIST_W-1:0] list_r;
  logic [RLIST_W-1:0] list_nxt_s;
  logic               dir_r;
  logic               dir_nxt_s;

  function automatic logic [RLIST_W-1:0] clear_lowest(input logic [RLIST_W-1:0] list);
    return list & (list - RLIST_W'(1));
  endfunction

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [RLIST_W-1:0] list);
    logic [IDX_W-1:0] idx;
    idx = {IDX_W{1'b0}};
    for (int i = RLIST_W - 1; i >= 0; i--) begin
      if (list[i]) begin
        idx = IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // An empty list yields a bubble rather than a micro-op.
  function automatic ctrl_t block_uop(input logic [RLIST_W-1:0] list, input logic dir);
    ctrl_t c;
    c = CTRL_ZERO;
    if (list != {RLIST_W{1'b0}}) begin
      c.vld  = 1'b1;
      c.cmd  = 4'b0010;
      c.idx  = lowest_idx(list);
      c.last = (clear_lowest(list) == {RLIST_W{1'b0}});
      c.wb    = dir;
      c.mem_r = dir;
      c.mem_w = ~dir;
    end else begin
      c = CTRL_ZERO;
    end
    return c;
  endfunction

  assign busy = (state_r == BLOCK);

  // Sequencer state, remaining register list and captured load/store direction
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      list_r  <= {RLIST_W{1'b0}};
      dir_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      list_r  <= list_nxt_s;
      dir_r   <= dir_nxt_s;
    end
  end
`else
  logic unused_rlist;

  assign unused_rlist = ^reg_list;
  assign busy         = 1'b0;
`endif

  assign in_ready = !stall && !busy && !flush;

  // Next control word and sequencer state; flush beats stall, stall holds everything
  always_comb begin
    ctrl_nxt_s = ctrl_r;
`ifdef CTRL_BLOCK_XFER_EN
    state_nxt_s = state_r;
    list_nxt_s  = list_r;
    dir_nxt_s   = dir_r;
`endif
    if (flush) begin
      ctrl_nxt_s = CTRL_ZERO;
`ifdef CTRL_BLOCK_XFER_EN
      state_nxt_s = IDLE;
      list_nxt_s  = {RLIST_W{1'b0}};
`endif
    end else if (stall) begin
      ctrl_nxt_s = ctrl_r;
`ifdef CTRL_BLOCK_XFER_EN
    end else if (state_r == BLOCK) begin
      ctrl_nxt_s = block_uop(list_r, dir_r);
      list_nxt_s = clear_lowest(list_r);
      if (clear_lowest(list_r) != {RLIST_W{1'b0}}) begin
        state_nxt_s = BLOCK;
      end else begin
        state_nxt_s = IDLE;
      end
    end else if (valid_in && (mode == 2'd3)) begin
      ctrl_nxt_s = block_uop(reg_list, s);
      list_nxt_s = clear_lowest(reg_list);
      dir_nxt_s  = s;
      if (clear_lowest(reg_list) != {RLIST_W{1'b0}}) begin
        state_nxt_s = BLOCK;
      end else begin
        state_nxt_s = IDLE;
      end
`endif
    end else if (valid_in) begin
      ctrl_nxt_s = decode_single(mode, opcode, s);
    end else begin
      ctrl_nxt_s = CTRL_ZERO;
    end
  end

  // Registered control word
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_r <= CTRL_ZERO;
    end else begin
      ctrl_r <= ctrl_nxt_s;
    end
  end

  assign out_valid   = ctrl_r.vld;
  assign mem_r_en    = ctrl_r.mem_r;
  assign mem_w_en    = ctrl_r.mem_w;
  assign wb_en       = ctrl_r.wb;
  assign b           = ctrl_r.br;
  assign stat_update = ctrl_r.stat;
  assign exe_cmd     = ctrl_r.cmd;
  assign uop_reg     = ctrl_r.idx;
  assign uop_last    = ctrl_r.last;

endmodule

// File: doc/ctrl_sequencer.md
CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

Interface
REQ-001 Parameter RLIST_W, default 16: width of the block-transfer register list (2..32).
REQ-002 Parameter IDX_W, default 4: width of uop_reg, equal to clog2(RLIST_W).
REQ-003 Port clk, input, 1: single clock, all state updates on the rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port valid_in, input, 1: the decode fields are valid this cycle.
REQ-006 Port mode, input, 2: instruction class (0 data-processing, 1 load/store, 2 branch, 3 block transfer).
REQ-007 Port opcode, input, 4: data-processing or memory opcode.
REQ-008 Port s, input, 1: S bit (status-update for mode 0, load/store select for modes 1 and 3).
REQ-009 Port reg_list, input, RLIST_W: register list for mode 3.
REQ-010 Port stall, input, 1: downstream hold.
REQ-011 Port flush, input, 1: pipeline kill.
REQ-012 Port in_ready, output, 1: an instruction is accepted this cycle.
REQ-013 Port busy, output, 1: a block transfer still has micro-ops pending.
REQ-014 Port out_valid, output, 1: the registered control word is valid.
REQ-015 Ports mem_r_en, mem_w_en, wb_en, b, stat_update are outputs, 1 bit each, registered.
REQ-016 Port exe_cmd, output, 4, registered: ALU command.
REQ-017 Port uop_reg, output, IDX_W, registered: register index of the current block-transfer micro-op.
REQ-018 Port uop_last, output, 1, registered: marks the final micro-op of a block transfer.

Function
REQ-019 in_ready SHALL equal !stall && !busy && !flush (combinational); an instruction is accepted when valid_in && in_ready.
REQ-020 Each accepted single-cycle instruction SHALL appear on the registered outputs with out_valid=1 one cycle after acceptance.
REQ-021 Mode 0 SHALL set stat_update=s and decode opcode to {exe_cmd, wb_en} as follows:
- 0 -> 0110,1
- 1 -> 1000,1
- 2 -> 0100,1
- 4 -> 0010,1
- 5 -> 0011,1
- 6 -> 0101,1
- 8 -> 0110,0
- 10 -> 0100,0
- 12 -> 0111,1
- 13 -> 0001,1
- 15 -> 1001,1
- any other opcode -> 0000,0
REQ-022 Mode 1 with opcode 4 SHALL set exe_cmd=0010; s=0 sets mem_w_en=1, s=1 sets wb_en=1 and mem_r_en=1; any other opcode gives all-zero controls; stat_update=0.
REQ-023 Mode 2 SHALL set b=1 with all other controls 0.
REQ-024 Mode 3 SHALL issue one micro-op per set bit of reg_list, in ascending index order, one per non-stalled cycle:
- exe_cmd=0010, uop_reg=bit index
- s=1: wb_en=1 and mem_r_en=1
- s=0: mem_w_en=1
REQ-025 Two states, IDLE and BLOCK:
- On accepting mode 3, the first micro-op is registered and the remaining list (lowest set bit cleared) is stored.
- A nonzero remaining list enters BLOCK; busy=1 in BLOCK.
- In BLOCK, each non-stalled cycle issues the lowest remaining bit and clears it.
- Return to IDLE when the remaining list reaches zero.
REQ-026 uop_last SHALL be 1 on the micro-op that empties the list, including a single-bit list; uop_last=0 and uop_reg=0 for all non-mode-3 words.
REQ-027 Mode 3 with reg_list=0 SHALL be accepted and produce out_valid=0 with all-zero controls (a bubble); busy stays 0.
REQ-028 A cycle with no acceptance in IDLE and stall=0 SHALL register a bubble: out_valid=0, all controls 0.
REQ-029 stall=1 SHALL hold every output register, the state and the remaining list unchanged.
REQ-030 flush=1 SHALL take priority over stall:
- clear out_valid and all controls to 0
- clear the remaining list
- force IDLE
- accept nothing that cycle

Reset
REQ-031 While rst=1 at a clock edge, all registered outputs, the state and the remaining list SHALL be 0/IDLE; reset mid-block aborts the transfer; rst overrides flush and stall.

Configuration
REQ-032 Macro CTRL_BLOCK_XFER_EN:
- Defined: the mode-3 sequencer per REQ-024..027.
- Undefined: mode 3 is accepted as a single-cycle bubble (out_valid=0, controls 0), busy is tied to 0, and no BLOCK state or list register exists.

Verification
REQ-033 Mode 0, opcode 4, s=1, accepted at T -> at T+1: out_valid=1, exe_cmd=0010, wb_en=1, stat_update=1.
REQ-034 Mode 3, s=1, reg_list=0x000B, accepted at T -> uop_reg 0,1,3 at T+1..T+3; uop_last=1 only at T+3; wb_en=mem_r_en=1 throughout; in_ready=0 at T+1,T+2 and 1 at T+3.
REQ-035 Same as REQ-034 with stall=1 at T+2 -> uop_reg=1 held at T+2 and T+3; uop_reg=3 at T+4.
REQ-036 Mode 3, s=0, reg_list=0x8001, with flush=1 at T+1 -> T+2: out_valid=0, busy=0, in_ready=1; register 15 is never issued.
REQ-037 Mode 1, opcode 3 -> all controls 0 with out_valid=1; mode 2 -> b=1 only; rst during BLOCK -> all outputs 0 the next cycle.
